// File: rtl/rom_port_arbiter.sv
// Two-port round-robin front end for the async-read program ROM.
// Word alignment, range check and a fixed 2-cycle registered read.
module rom_port_arbiter #(
  parameter logic [15:0] ROM_BASE = 16'hC000,
  parameter logic [15:0] ERR_DATA = 16'h3FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_gnt,
  output logic        f_ack,
  output logic        f_err,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic        d_bw,
  output logic        d_gnt,
  output logic        d_ack,
  output logic        d_err,
  output logic [15:0] rdata,
  output logic [15:0] rom_addr,
  output logic        BW,
  input  logic [15:0] rom_out
);

  typedef enum logic {
    PORT_F = 1'b0,
    PORT_D = 1'b1
  } port_t;

  typedef struct packed {
    logic  valid;
    port_t owner;
    logic  err;
  } s1_t;

  port_t       rr_q;
  port_t       rr_d;
  logic        gnt_any;
  port_t       gnt_port;
  logic [15:0] sel_addr;
  logic [15:0] aln_addr;
  logic        sel_bw;
  logic        sel_err;
  s1_t         s1_q;
  s1_t         s1_d;

  // Grant one requester; pointer moves to the loser on every grant
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    rr_d  = rr_q;
    if (!rst) begin
      unique case (1'b1)
        f_req && !d_req: f_gnt = 1'b1;
        d_req && !f_req: d_gnt = 1'b1;
        f_req && d_req: begin
          f_gnt = (rr_q == PORT_F);
          d_gnt = (rr_q == PORT_D);
        end
        default: ;
      endcase
      if (f_gnt) begin
        rr_d = PORT_D;
      end else if (d_gnt) begin
        rr_d = PORT_F;
      end
    end
  end

  // Mux the winner, align words, flag accesses below the ROM
  always_comb begin
    gnt_any  = f_gnt | d_gnt;
    gnt_port = d_gnt ? PORT_D : PORT_F;
    sel_addr = d_gnt ? d_addr : f_addr;
    sel_bw   = d_gnt & d_bw;
    aln_addr = sel_bw ? sel_addr
                      : {sel_addr[15:1], 1'b0};
    sel_err  = (sel_addr < ROM_BASE);
    s1_d.valid = gnt_any;
    s1_d.owner = gnt_port;
    s1_d.err   = sel_err;
  end

  // Round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= PORT_F;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Stage 1: drive the ROM; address holds when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      BW       <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_q <= s1_d;
      if (gnt_any) begin
        rom_addr <= aln_addr;
        BW       <= sel_bw;
      end
    end
  end

  // Stage 2: capture ROM data and return it to the owner
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      f_err <= 1'b0;
      d_err <= 1'b0;
    end else if (s1_q.valid) begin
      rdata <= s1_q.err ? ERR_DATA : rom_out;
      f_ack <= (s1_q.owner == PORT_F);
      d_ack <= (s1_q.owner == PORT_D);
      f_err <= (s1_q.owner == PORT_F) & s1_q.err;
      d_err <= (s1_q.owner == PORT_D) & s1_q.err;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      f_err <= 1'b0;
      d_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: ROM model, grant checks per task,
// and a scoreboard that matches acks against granted accesses.
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0;
  logic [15:0] f_addr = '0;
  logic        f_gnt, f_ack, f_err;
  logic        d_req = 1'b0;
  logic [15:0] d_addr = '0;
  logic        d_bw = 1'b0;
  logic        d_gnt, d_ack, d_err;
  logic [15:0] rdata, rom_addr, rom_out;
  logic        BW;

  always #5 clk = ~clk;

  rom_port_arbiter dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_ack(f_ack), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_bw(d_bw),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_err(d_err),
    .rdata(rdata), .rom_addr(rom_addr), .BW(BW),
    .rom_out(rom_out)
  );

  function automatic logic [15:0] rom_model(
    input logic [15:0] a, input logic bw);
    logic [15:0] w;
    w = ({a[15:1], 1'b0} * 16'd3) ^ 16'h5A3C;
    if (bw) return {8'h00, a[0] ? w[15:8] : w[7:0]};
    return w;
  endfunction

  assign rom_out = rom_model(rom_addr, BW);

  typedef struct {
    int          cyc;
    bit          port;
    bit          err;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   rr_exp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_exp(
    input bit port, input logic [15:0] a, input bit bw);
    exp_t e;
    logic [15:0] al;
    al = bw ? a : {a[15:1], 1'b0};
    e.cyc  = cyc + 2;
    e.port = port;
    e.err  = (a < 16'hC000);
    e.data = e.err ? 16'h3FFF : rom_model(al, bw);
    sb.push_back(e);
    rr_exp = !port;
  endfunction

  // Scoreboard: every ack must match the oldest outstanding grant
  always @(negedge clk) begin
    exp_t e;
    bit has, ef, ed;
    has = 0; ef = 0; ed = 0;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL lost_ack: cyc %0d got none want port %0d",
                 sb[0].cyc, sb[0].port);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        has = 1; ef = (e.port == 0); ed = (e.port == 1);
      end
      if (has || f_ack === 1'b1 || d_ack === 1'b1) begin
        n_cmp++;
        if (f_ack !== ef) begin
          n_bad++;
          $display("FAIL f_ack cyc %0d: got %b want %b", cyc, f_ack, ef);
        end
        n_cmp++;
        if (d_ack !== ed) begin
          n_bad++;
          $display("FAIL d_ack cyc %0d: got %b want %b", cyc, d_ack, ed);
        end
      end
      if (has) begin
        n_cmp++;
        if (f_err !== (ef & e.err) || d_err !== (ed & e.err)) begin
          n_bad++;
          $display("FAIL err cyc %0d: got f%b d%b want %b port %0d",
                   cyc, f_err, d_err, e.err, e.port);
        end
        n_cmp++;
        if (rdata !== e.data) begin
          n_bad++;
          $display("FAIL rdata cyc %0d: got %h want %h",
                   cyc, rdata, e.data);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      f_req = 0; d_req = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1; f_req = 1; d_req = 1;
    f_addr = 16'hC000; d_addr = 16'hD000; d_bw = 0;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (f_gnt !== 1'b0 || d_gnt !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_gnt: got f%b d%b want 0 0", f_gnt, d_gnt);
      end
      n_cmp++;
      if ({f_ack, d_ack, f_err, d_err, rdata, rom_addr, BW} !== '0) begin
        n_bad++;
        $display("FAIL reset_out: got %b%b%b%b %h %h %b want zeros",
                 f_ack, d_ack, f_err, d_err, rdata, rom_addr, BW);
      end
    end
    @(posedge clk); #1;
    rst = 0; sb.delete(); rr_exp = 0;
    @(negedge clk);
    n_cmp++;
    if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      n_bad++;
      $display("FAIL release_gnt: got f%b d%b want 1 0", f_gnt, d_gnt);
    end
    if (f_gnt === 1'b1) push_exp(0, f_addr, 0);
    idle(3);
  endtask

  task automatic test_single_fetch();
    logic [15:0] a [2];
    logic [15:0] w [2];
    a[0] = 16'hC003; w[0] = 16'hC002;
    a[1] = 16'hFFFF; w[1] = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      f_req = 1; f_addr = a[i];
      @(negedge clk);
      n_cmp++;
      if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin
        n_bad++;
        $display("FAIL fetch_gnt: got f%b d%b want 1 0", f_gnt, d_gnt);
      end
      if (f_gnt === 1'b1) push_exp(0, a[i], 0);
      @(posedge clk); #1;
      f_req = 0;
      @(negedge clk);
      n_cmp++;
      if (rom_addr !== w[i] || BW !== 1'b0) begin
        n_bad++;
        $display("FAIL fetch_align: got %h bw%b want %h bw0",
                 rom_addr, BW, w[i]);
      end
      idle(2);
    end
  endtask

  task automatic test_contention();
    bit ef, prev_d;
    @(posedge clk); #1;
    d_req = 1; d_addr = 16'hE100; d_bw = 0;
    @(negedge clk);
    n_cmp++;
    if (d_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL lone_d_gnt: got %b want 1", d_gnt);
    end
    if (d_gnt === 1'b1) push_exp(1, d_addr, 0);
    prev_d = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      f_req = (i < 4); f_addr = 16'hC010;
      d_req = (i < 4); d_addr = 16'hE001; d_bw = 1;
      @(negedge clk);
      if (prev_d) begin
        n_cmp++;
        if (rom_addr !== 16'hE001 || BW !== 1'b1) begin
          n_bad++;
          $display("FAIL cont_daddr: got %h bw%b want e001 bw1",
                   rom_addr, BW);
        end
      end
      prev_d = 0;
      if (i < 4) begin
        ef = (rr_exp == 0);
        n_cmp++;
        if (f_gnt !== ef || d_gnt !== !ef) begin
          n_bad++;
          $display("FAIL cont_gnt %0d: got f%b d%b want f%b d%b",
                   i, f_gnt, d_gnt, ef, !ef);
        end
        if (ef) push_exp(0, f_addr, 0);
        else push_exp(1, d_addr, d_bw);
        prev_d = !ef;
      end
    end
    idle(2);
  endtask

  task automatic test_range_error();
    @(posedge clk); #1;
    d_req = 1; d_addr = 16'h0200; d_bw = 0;
    @(negedge clk);
    n_cmp++;
    if (d_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL rerr_gnt: got %b want 1", d_gnt);
    end
    if (d_gnt === 1'b1) push_exp(1, d_addr, 0);
    @(posedge clk); #1;
    d_req = 0; f_req = 1; f_addr = 16'hC100;
    @(negedge clk);
    n_cmp++;
    if (f_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL rerr_fgnt: got %b want 1", f_gnt);
    end
    if (f_gnt === 1'b1) push_exp(0, f_addr, 0);
    idle(3);
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      f_req = 1; f_addr = 16'hFFF8 + 16'(2 * i);
      @(negedge clk);
      n_cmp++;
      if (f_gnt !== 1'b1) begin
        n_bad++;
        $display("FAIL stream_gnt %0d: got %b want 1", i, f_gnt);
      end
      if (f_gnt === 1'b1) push_exp(0, f_addr, 0);
    end
    idle(3);
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    d_req = 1; d_addr = 16'hE002; d_bw = 0;
    @(negedge clk);
    n_cmp++;
    if (d_gnt !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_gnt: got %b want 1", d_gnt);
    end
    @(posedge clk); #1;
    d_req = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0; rr_exp = 0;
    @(negedge clk);
    n_cmp++;
    if ({f_ack, d_ack, f_err, d_err, rdata, rom_addr, BW} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got %b%b%b%b %h %h %b want zeros",
               f_ack, d_ack, f_err, d_err, rdata, rom_addr, BW);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    bit fp, dp, ef, ed;
    fp = 0; dp = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!fp) begin
        f_req = 1'($urandom_range(0, 1));
        f_addr = 16'($urandom);
      end
      if (!dp) begin
        d_req = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom);
        d_bw = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      ef = f_req && (!d_req || rr_exp == 0);
      ed = d_req && !ef;
      n_cmp++;
      if (f_gnt !== ef || d_gnt !== ed) begin
        n_bad++;
        $display("FAIL b2b_gnt %0d: got f%b d%b want f%b d%b",
                 i, f_gnt, d_gnt, ef, ed);
      end
      if (ef) push_exp(0, f_addr, 0);
      else if (ed) push_exp(1, d_addr, d_bw);
      fp = f_req && !ef;
      dp = d_req && !ed;
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_range_error();
    test_contention();
    test_streaming();
    test_reset_midflight();
    test_back_to_back();
    for (int i = 0; i < 5 && sb.size() > 0; i++) idle(1);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single asynchronous-read program ROM (16-bit rom_addr, BW byte/word select, 16-bit rom_out) between two requesters: instruction fetch (port F) and data/operand read (port D).
- Performs round-robin arbitration and word alignment.
- Range-checks each access against the ROM window.
- Returns registered read data with a fixed 2-cycle latency; a new access can be issued every cycle.
- Sits between the CPU front end / execution unit and the rom instance.

Parameters:
- ROM_BASE, 16'hC000, lowest byte address decoded as ROM. Accesses below this are range errors.
- ERR_DATA, 16'h3FFF, value returned on a range error (MSP430 "JMP $" opcode).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- f_req  input  1  fetch request
- f_addr  input  16  fetch byte address
- f_gnt  output  1  fetch request accepted this cycle (combinational)
- f_ack  output  1  fetch data valid (registered)
- f_err  output  1  fetch range error, qualified by f_ack
- d_req  input  1  data request
- d_addr  input  16  data byte address
- d_bw  input  1  data width: 0 = word, 1 = byte
- d_gnt  output  1  data request accepted this cycle (combinational)
- d_ack  output  1  data valid (registered)
- d_err  output  1  data range error, qualified by d_ack
- rdata  output  16  read data for whichever port has ack high
- rom_addr  output  16  registered address to rom
- BW  output  1  registered byte/word select to rom
- rom_out  input  16  rom read data, combinational from rom_addr/BW

Behaviour:
- Reset (rst high at an edge): rom_addr=0, BW=0, f_ack=d_ack=0, f_err=d_err=0, rdata=0, pipeline stage-1 valid=0, rr pointer=F (fetch preferred next). f_gnt and d_gnt are forced 0 while rst is high.
- Fetch is always a word access (BW=0).
- Arbitration, combinational in cycle N:
  - Only one requester: it gets gnt.
  - Both requesting: the port indicated by the rr pointer gets gnt; the other gets gnt=0 and must hold req/addr.
  - On every grant, rr pointer updates at the edge to the non-granted port. With back-to-back contention, grants therefore alternate F, D, F, D, ...
  - Neither requesting: no grant; rr pointer unchanged.
- Alignment: for word accesses, address bit 0 is forced to 0 before driving rom_addr. For byte accesses, the address passes unchanged and the rom selects the byte.
- Stage 1 (edge ending cycle N): latch aligned address into rom_addr and width into BW. Latch owner (F/D), valid=1, and err = (addr < ROM_BASE). With no grant, valid=0 and rom_addr/BW hold their previous values.
- Stage 2 (edge ending N+1): if stage-1 valid:
  - rdata = err ? ERR_DATA : rom_out.
  - Owner's ack=1 and owner's err=err; the other port's ack=0 and err=0.
  - If stage-1 is not valid: both acks 0, both errs 0, rdata holds.
- Latency: request granted in N → ack and rdata visible in N+2.
- Throughput: one grant per cycle. The pipeline never stalls because the rom is combinational.
- A port can hold at most one outstanding grant per cycle. Acks return in grant order.
- Simultaneous grant in N and ack in N+2 for different ports is legal. Each ack stays high exactly one cycle per grant.
- rst asserted mid-operation: in-flight accesses are discarded (no ack is ever issued for them), and all outputs return to reset values at that edge.
- Address wrap: 16'hFFFF word access → rom_addr 16'hFFFE. There is no carry or overflow; addressing is modulo 2^16.

Test Plan:
- Reset: hold rst 2 cycles with f_req=d_req=1 → f_gnt=d_gnt=0 throughout, all outputs 0. First cycle after release: f_gnt=1, d_gnt=0 (rr=F).
- Single fetch: f_req=1, f_addr=16'hC003 in cycle N → f_gnt=1 in N; rom_addr=16'hC002 and BW=0 in N+1; f_ack=1, f_err=0, rdata=ROM word at C002 in N+2.
- Contention: f_req=d_req=1 held 4 cycles (d_addr=16'hE001, d_bw=1) → grants F, D, F, D. Acks follow 2 cycles later in the same order. D access shows BW=1, rom_addr=16'hE001, and rdata=rom_out for that access.
- Range error: d_req with d_addr=16'h0200 → d_ack=1, d_err=1, rdata=16'h3FFF in N+2. A subsequent in-range F access returns f_err=0.
- Streaming: f_req held high 8 cycles, addr stepping by 2 from 16'hFFF8 (wraps to 16'h0000 and out of range) → f_ack high 8 consecutive cycles starting N+2. The last four accesses (16'h0000–16'h0006) report f_err=1.
- Reset mid-flight: grant D in N, assert rst at the end of N+1 → no d_ack in N+2; all outputs are at reset values.
